// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
//   Memory-stage controller that sits directly in front of the load/store unit.
//   It takes one decoded op at a time from EX and checks the op's alignment.
//   Aligned loads and stores are handed to the lsu through its read and write
//   handshakes. Non-memory ops and misaligned accesses go straight to the result
//   stage. Exactly one result per op is presented to WB. At most one op is in
//   flight at any time.
//
//   Parameter
//     TIMEOUT      cycles to wait for an lsu acknowledge before the op is
//                  aborted with out_fault=1; 0 waits forever
//
//   Ports
//     clk, rst     clock and synchronous active-low reset
//     in_*         op from EX (valid/ready handshake, decoded fields)
//     funct3       width code of the op in flight, to the lsu
//     lsu_addr     byte address of the op in flight, to the lsu
//     lsu_r_*      read request / read data-valid handshake with the lsu
//     lsu_w_*      write request / write-accepted handshake with the lsu
//     out_*        result to WB (valid/ready handshake, data, rd, flags)
// -----------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 32'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [63:0] in_wdata,
    input  logic [63:0] in_alu_res,
    input  logic [4:0]  in_rd,
    output logic [2:0]  funct3,
    output logic [31:0] lsu_addr,
    output logic        lsu_r_ready,
    input  logic        lsu_r_valid,
    input  logic [63:0] lsu_r_data,
    output logic        lsu_w_valid,
    output logic [63:0] lsu_w_data,
    input  logic        lsu_w_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic        out_misalign,
    output logic        out_fault
);

    localparam int unsigned CW = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT + 32'd1) : 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Natural alignment check: the low address bits must be zero for the
    // access width (byte, half, word, double), selected by funct3[1:0].
    function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] a);
        logic bad;
        case (f3[1:0])
            2'd0:    bad = 1'b0;
            2'd1:    bad = a[0];
            2'd2:    bad = |a[1:0];
            2'd3:    bad = |a[2:0];
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    state_t        state_r, state_nx;
    logic [CW-1:0] cnt_r, cnt_nx;
    logic [2:0]    funct3_r, funct3_nx;
    logic [31:0]   addr_r, addr_nx;
    logic [63:0]   wdata_r, wdata_nx;
    logic [4:0]    rd_r, rd_nx;
    logic          r_ready_r, r_ready_nx;
    logic          w_valid_r, w_valid_nx;
    logic          out_valid_r, out_valid_nx;
    logic [63:0]   out_data_r, out_data_nx;
    logic [4:0]    out_rd_r, out_rd_nx;
    logic          out_wen_r, out_wen_nx;
    logic          out_misalign_r, out_misalign_nx;
    logic          out_fault_r, out_fault_nx;

    logic          in_ready_s;
    logic          accept_s;
    logic          misalign_s;
    logic          timeout_hit_s;

    assign in_ready_s    = (state_r == ST_IDLE) | ((state_r == ST_RESP) & out_ready);
    assign accept_s      = in_valid & in_ready_s;
    assign misalign_s    = misaligned(in_funct3, in_addr[2:0]);
    assign timeout_hit_s = (TIMEOUT != 32'd0) && (cnt_r == CW'(TIMEOUT));

    assign in_ready     = in_ready_s;
    assign funct3       = funct3_r;
    assign lsu_addr     = addr_r;
    assign lsu_w_data   = wdata_r;
    assign lsu_r_ready  = r_ready_r;
    assign lsu_w_valid  = w_valid_r;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_rd       = out_rd_r;
    assign out_wen      = out_wen_r;
    assign out_misalign = out_misalign_r;
    assign out_fault    = out_fault_r;

    // Next-state, op-register and result computation.
    always_comb begin
        state_nx        = state_r;
        cnt_nx          = cnt_r;
        funct3_nx       = funct3_r;
        addr_nx         = addr_r;
        wdata_nx        = wdata_r;
        rd_nx           = rd_r;
        out_valid_nx    = out_valid_r;
        out_data_nx     = out_data_r;
        out_rd_nx       = out_rd_r;
        out_wen_nx      = out_wen_r;
        out_misalign_nx = out_misalign_r;
        out_fault_nx    = out_fault_r;

        case (state_r)
            ST_IDLE: begin
                state_nx = ST_IDLE;
            end
            ST_RD: begin
                // An ack on the expiry cycle still completes the load.
                if (lsu_r_valid) begin
                    state_nx     = ST_RESP;
                    out_valid_nx = 1'b1;
                    out_data_nx  = lsu_r_data;
                    out_rd_nx    = rd_r;
                    out_wen_nx   = (rd_r != 5'd0);
                end else if (timeout_hit_s) begin
                    state_nx     = ST_RESP;
                    out_valid_nx = 1'b1;
                    out_data_nx  = 64'd0;
                    out_rd_nx    = rd_r;
                    out_wen_nx   = 1'b0;
                    out_fault_nx = 1'b1;
                end else if (TIMEOUT != 32'd0) begin
                    cnt_nx = cnt_r + CW'(1'b1);
                end else begin
                    cnt_nx = cnt_r;
                end
            end
            ST_WR: begin
                if (lsu_w_ready) begin
                    state_nx     = ST_RESP;
                    out_valid_nx = 1'b1;
                    out_data_nx  = 64'd0;
                    out_rd_nx    = rd_r;
                    out_wen_nx   = 1'b0;
                end else if (timeout_hit_s) begin
                    state_nx     = ST_RESP;
                    out_valid_nx = 1'b1;
                    out_data_nx  = 64'd0;
                    out_rd_nx    = rd_r;
                    out_wen_nx   = 1'b0;
                    out_fault_nx = 1'b1;
                end else if (TIMEOUT != 32'd0) begin
                    cnt_nx = cnt_r + CW'(1'b1);
                end else begin
                    cnt_nx = cnt_r;
                end
            end
            ST_RESP: begin
                // Result taken: return to an all-zero idle unless a new op is
                // accepted below in the same cycle.
                if (out_ready) begin
                    state_nx        = ST_IDLE;
                    funct3_nx       = 3'd0;
                    addr_nx         = 32'd0;
                    wdata_nx        = 64'd0;
                    rd_nx           = 5'd0;
                    out_valid_nx    = 1'b0;
                    out_data_nx     = 64'd0;
                    out_rd_nx       = 5'd0;
                    out_wen_nx      = 1'b0;
                    out_misalign_nx = 1'b0;
                    out_fault_nx    = 1'b0;
                end else begin
                    state_nx = ST_RESP;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Accepting an op (from IDLE, or back-to-back from RESP) overrides
        // whatever the state decode chose above.
        if (accept_s) begin
            funct3_nx       = in_funct3;
            addr_nx         = in_addr;
            wdata_nx        = in_wdata;
            rd_nx           = in_rd;
            cnt_nx          = '0;
            out_valid_nx    = 1'b0;
            out_data_nx     = 64'd0;
            out_rd_nx       = 5'd0;
            out_wen_nx      = 1'b0;
            out_misalign_nx = 1'b0;
            out_fault_nx    = 1'b0;
            if (!(in_is_load | in_is_store)) begin
                state_nx     = ST_RESP;
                out_valid_nx = 1'b1;
                out_data_nx  = in_alu_res;
                out_rd_nx    = in_rd;
                out_wen_nx   = (in_rd != 5'd0);
            end else if (misalign_s) begin
                state_nx        = ST_RESP;
                out_valid_nx    = 1'b1;
                out_rd_nx       = in_rd;
                out_misalign_nx = 1'b1;
            end else if (in_is_load) begin
                state_nx = ST_RD;
            end else begin
                state_nx = ST_WR;
            end
        end else begin
            cnt_nx = cnt_nx;
        end

        // Strobes are registered from the next state, so they drop on the
        // cycle after the ack and never repeat a completed transfer.
        r_ready_nx = (state_nx == ST_RD);
        w_valid_nx = (state_nx == ST_WR);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r        <= ST_IDLE;
            cnt_r          <= '0;
            funct3_r       <= 3'd0;
            addr_r         <= 32'd0;
            wdata_r        <= 64'd0;
            rd_r           <= 5'd0;
            r_ready_r      <= 1'b0;
            w_valid_r      <= 1'b0;
            out_valid_r    <= 1'b0;
            out_data_r     <= 64'd0;
            out_rd_r       <= 5'd0;
            out_wen_r      <= 1'b0;
            out_misalign_r <= 1'b0;
            out_fault_r    <= 1'b0;
        end else begin
            state_r        <= state_nx;
            cnt_r          <= cnt_nx;
            funct3_r       <= funct3_nx;
            addr_r         <= addr_nx;
            wdata_r        <= wdata_nx;
            rd_r           <= rd_nx;
            r_ready_r      <= r_ready_nx;
            w_valid_r      <= w_valid_nx;
            out_valid_r    <= out_valid_nx;
            out_data_r     <= out_data_nx;
            out_rd_r       <= out_rd_nx;
            out_wen_r      <= out_wen_nx;
            out_misalign_r <= out_misalign_nx;
            out_fault_r    <= out_fault_nx;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl
//   Self-checking bench for lsu_ctrl (built with TIMEOUT=4). A small lsu model
//   acknowledges requests one cycle after it sees them, unless acks are
//   disabled. Expected results are queued when an op is issued and compared
//   when WB takes the result.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_is_load, in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [63:0] in_wdata, in_alu_res;
    logic [4:0]  in_rd;
    logic [2:0]  funct3;
    logic [31:0] lsu_addr;
    logic        lsu_r_ready;
    logic        lsu_r_valid = 1'b0;
    logic [63:0] lsu_r_data  = 64'h1122334455667788;
    logic        lsu_w_valid;
    logic [63:0] lsu_w_data;
    logic        lsu_w_ready = 1'b0;
    logic        out_valid, out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        out_wen, out_misalign, out_fault;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic        mis;
        logic        flt;
        logic        chk_data;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        sb_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          r_cnt    = 0;
    int          w_cnt    = 0;
    logic [63:0] w_seen   = 64'd0;
    logic        r_ack_en = 1'b1;
    logic        w_ack_en = 1'b1;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT(32'd4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_alu_res(in_alu_res), .in_rd(in_rd),
        .funct3(funct3), .lsu_addr(lsu_addr),
        .lsu_r_ready(lsu_r_ready), .lsu_r_valid(lsu_r_valid), .lsu_r_data(lsu_r_data),
        .lsu_w_valid(lsu_w_valid), .lsu_w_data(lsu_w_data), .lsu_w_ready(lsu_w_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_wen(out_wen), .out_misalign(out_misalign),
        .out_fault(out_fault)
    );

    // lsu model: registered one-cycle ack pulse per request.
    always @(posedge clk) begin
        if (!rst) begin
            lsu_r_valid <= 1'b0;
            lsu_w_ready <= 1'b0;
        end else begin
            lsu_r_valid <= r_ack_en && lsu_r_ready && !lsu_r_valid;
            lsu_w_ready <= w_ack_en && lsu_w_valid && !lsu_w_ready;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe monitor and scoreboard, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (lsu_r_ready === 1'b1) r_cnt++;
            if (lsu_w_valid === 1'b1) begin
                w_cnt++;
                w_seen = lsu_w_data;
            end
            if (rst && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_unexpected_result", 64'd1, 64'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check_val("sb_rd", 64'(out_rd), 64'(sb_e.rd));
                    check_val("sb_wen", 64'(out_wen), 64'(sb_e.wen));
                    check_val("sb_misalign", 64'(out_misalign), 64'(sb_e.mis));
                    check_val("sb_fault", 64'(out_fault), 64'(sb_e.flt));
                    if (sb_e.chk_data) check_val("sb_data", out_data, sb_e.data);
                end
            end
        end
    end

    task automatic push_exp(input logic [63:0] d, input logic [4:0] rd, input logic wen,
                            input logic mis, input logic flt, input logic chk);
        exp_t e;
        e.data = d; e.rd = rd; e.wen = wen; e.mis = mis; e.flt = flt; e.chk_data = chk;
        sb_q.push_back(e);
    endtask

    // Offer one op and return 1 time unit after the edge that accepted it.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [63:0] wd,
                         input logic [63:0] alu, input logic [4:0] rd);
        logic ok;
        ok = 1'b0;
        in_is_load = ld; in_is_store = st; in_funct3 = f3; in_addr = addr;
        in_wdata = wd; in_alu_res = alu; in_rd = rd; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_valid = 1'b0;
        check_val("issue_accepted", 64'(ok), 64'd1);
    endtask

    // Cycles counted from the accept cycle (cycle 0) until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int r0, w0;
        logic ov_seen;
        rst = 1'b0; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        in_funct3 = 3'd0; in_addr = 32'd0; in_wdata = 64'd0; in_alu_res = 64'd0;
        in_rd = 5'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_r_ready", 64'(lsu_r_ready), 64'd0);
        check_val("rst_w_valid", 64'(lsu_w_valid), 64'd0);
        check_val("rst_lsu_addr", 64'(lsu_addr), 64'd0);
        check_val("rst_funct3", 64'(funct3), 64'd0);
        check_val("rst_out_data", out_data, 64'd0);
        check_val("rst_out_wen", 64'(out_wen), 64'd0);
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Aligned LD, ack one cycle after the request.
        r0 = r_cnt;
        push_exp(64'h1122334455667788, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 3'd3, 32'h80000008, 64'd0, 64'd0, 5'd7);
        check_val("ld_lsu_addr", 64'(lsu_addr), 64'h80000008);
        check_val("ld_funct3", 64'(funct3), 64'd3);
        wait_valid(lat);
        check_val("ld_latency", 64'(lat), 64'd3);
        check_val("ld_r_ready_cycles", 64'(r_cnt - r0), 64'd2);
        @(posedge clk);
        #1;

        // Aligned SW: two write-strobe cycles, result the cycle after.
        w0 = w_cnt;
        push_exp(64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 3'd2, 32'h80000004, 64'hDEADBEEF, 64'd0, 5'd0);
        wait_valid(lat);
        check_val("sw_latency", 64'(lat), 64'd3);
        check_val("sw_w_valid_cycles", 64'(w_cnt - w0), 64'd2);
        check_val("sw_w_data", w_seen, 64'hDEADBEEF);
        check_val("sw_w_valid_dropped", 64'(lsu_w_valid), 64'd0);
        @(posedge clk);
        #1;

        // Misaligned LW: no read request, result next cycle.
        r0 = r_cnt;
        push_exp(64'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 3'd2, 32'h80000002, 64'd0, 64'h55, 5'd9);
        wait_valid(lat);
        check_val("lw_mis_latency", 64'(lat), 64'd1);
        check_val("lw_mis_no_r_ready", 64'(r_cnt - r0), 64'd0);
        @(posedge clk);
        #1;

        // Misaligned SH: no write request.
        w0 = w_cnt;
        push_exp(64'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(1'b0, 1'b1, 3'd1, 32'h80000003, 64'h1234, 64'd0, 5'd0);
        wait_valid(lat);
        check_val("sh_mis_latency", 64'(lat), 64'd1);
        check_val("sh_mis_no_w_valid", 64'(w_cnt - w0), 64'd0);
        @(posedge clk);
        #1;

        // LB with no ack: five request cycles, then fault.
        r_ack_en = 1'b0;
        r0 = r_cnt;
        push_exp(64'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
        issue(1'b1, 1'b0, 3'd0, 32'h80000001, 64'd0, 64'd0, 5'd5);
        wait_valid(lat);
        check_val("to_latency", 64'(lat), 64'd6);
        check_val("to_r_ready_cycles", 64'(r_cnt - r0), 64'd5);
        check_val("to_r_ready_dropped", 64'(lsu_r_ready), 64'd0);
        r_ack_en = 1'b1;
        @(posedge clk);
        #1;

        // Two ALU ops back-to-back, then WB stalls for three cycles.
        push_exp(64'hA5A5_0000_1111_2222, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        push_exp(64'h0BAD_F00D_CAFE_0001, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        in_is_load = 1'b0; in_is_store = 1'b0; in_alu_res = 64'hA5A5_0000_1111_2222;
        in_rd = 5'd3; in_valid = 1'b1;
        #1;
        check_val("alu_a_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        check_val("alu_a_out_valid", 64'(out_valid), 64'd1);
        check_val("alu_a_out_data", out_data, 64'hA5A5_0000_1111_2222);
        in_alu_res = 64'h0BAD_F00D_CAFE_0001; in_rd = 5'd0;
        #1;
        check_val("alu_b_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        check_val("alu_b_out_valid", 64'(out_valid), 64'd1);
        check_val("alu_b_out_data", out_data, 64'h0BAD_F00D_CAFE_0001);
        out_ready = 1'b0;
        in_alu_res = 64'h7777; in_rd = 5'd4;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("stall_in_ready", 64'(in_ready), 64'd0);
            check_val("stall_out_valid", 64'(out_valid), 64'd1);
            check_val("stall_out_data", out_data, 64'h0BAD_F00D_CAFE_0001);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("stall_release_idle", 64'(out_valid), 64'd0);

        // Reset in the middle of a store that the lsu never acknowledges.
        w_ack_en = 1'b0;
        issue(1'b0, 1'b1, 3'd3, 32'h80000010, 64'h0123456789ABCDEF, 64'd0, 5'd1);
        check_val("rstwr_w_valid_high", 64'(lsu_w_valid), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("rstwr_w_valid_low", 64'(lsu_w_valid), 64'd0);
        check_val("rstwr_out_valid", 64'(out_valid), 64'd0);
        check_val("rstwr_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b1;
        w_ack_en = 1'b1;
        ov_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            ov_seen = ov_seen | out_valid;
        end
        check_val("rstwr_no_result", 64'(ov_seen), 64'd0);

        check_val("sb_all_results_seen", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
